dcache_burst_controller: RTL
============================

Name: dcache_burst_controller

Overview:
- Parametrised data-cache controller for the RISC-V L1 D-cache. It sits between the pipeline memory stage, the D-cache data/tag array and a narrower main-memory bus.
- It serves read and write hits in zero extra cycles.
- On a miss it writes back the dirty victim and refills the block as multi-beat valid/ready bursts, then merges any pending store into the refilled block.
- It also keeps saturating hit, miss and write-back counters.

Parameters:
- ADDR_W, 32, byte-address width.
- WORD_W, 32, pipeline word width in bits; multiple of 8.
- BLOCK_WORDS, 4, words per cache block; power of 2, at least 1.
- MEM_W, 32, memory bus beat width. BLOCK_W = BLOCK_WORDS*WORD_W must be a multiple of MEM_W.
- CNT_W, 16, width of the performance counters.
- Derived: BLOCK_W; BEATS = BLOCK_W/MEM_W; WOFF_W = log2(WORD_W/8); BOFF_W = WOFF_W + log2(BLOCK_WORDS); BA_W = ADDR_W - BOFF_W.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ren, wen  in  1 each  pipeline read/write request.
- addr  in  ADDR_W  byte address.
- byte_sel  in  WORD_W/8  store byte enables.
- din  in  WORD_W  store data.
- stall  out  1  freeze pipeline.
- dout  out  WORD_W  load data.
- cache_hit, cache_dirty  in  1 each  lookup result for addr; victim dirty bit.
- cache_victim_ba  in  BA_W  block address of the victim line.
- cache_dout  in  BLOCK_W  block read from the array (victim on miss).
- cache_en, cache_wen, cache_fill  out  1 each  array access, partial write, full-block fill.
- cache_byte_en  out  BLOCK_W/8  byte enables into the array.
- cache_din  out  BLOCK_W  write data into the array.
- cache_set_dirty  out  1  dirty bit to store with this write.
- mem_req_valid, mem_req_write  out  1 each  burst request; 1 = write-back.
- mem_req_ready  in  1  request accepted.
- mem_block_addr  out  BA_W  burst block address.
- mem_wdata  out  MEM_W  write beat.
- mem_wvalid  out  1  write beat valid.
- mem_wready  in  1  write beat accepted.
- mem_rdata  in  MEM_W  read beat.
- mem_rvalid  in  1  read beat valid; no backpressure.
- hit_count, miss_count, wb_count  out  CNT_W each  performance counters.

Behaviour:
- Request qualification
  - req = ren|wen.
  - If ren and wen are both high, the request is a write.
  - woff = addr[BOFF_W-1:WOFF_W].
- Reset and idle outputs
  - Reset puts the FSM in IDLE and clears the beat counter, buffers and all counters.
  - All enables, valids, stall and dout are 0 while in reset and in IDLE with no req.
  - Reset mid-burst abandons the transfer with no further handshakes; memory is reset with it.
- IDLE, read hit: dout = word woff of cache_dout, stall=0, hit_count++.
- IDLE, write hit (same cycle, combinational):
  - cache_en=cache_wen=1.
  - cache_byte_en = byte_sel shifted to word woff.
  - cache_din = din replicated across all words.
  - cache_set_dirty = |byte_sel.
  - stall=0, hit_count++.
- IDLE, miss (req & !cache_hit):
  - stall=1 in the same cycle; miss_count++.
  - Latch addr, din, byte_sel, the write flag, cache_victim_ba and cache_dout (victim buffer).
  - Next state is WB_REQ if cache_dirty (wb_count++), else RD_REQ.
- WB_REQ: mem_req_valid=1, mem_req_write=1, mem_block_addr=victim; on mem_req_ready, beat counter←0 and go to WB_DATA.
- WB_DATA:
  - mem_wvalid=1; mem_wdata = victim buffer beat[cnt]. Beat 0 is the least-significant MEM_W bits.
  - Each mem_wready advances cnt. Acceptance of beat BEATS-1 goes to RD_REQ.
  - mem_wdata must stay stable while wvalid && !wready.
- RD_REQ: mem_req_valid=1, mem_req_write=0, mem_block_addr = latched addr block; on ready, cnt←0 and go to RD_DATA.
- RD_DATA: each mem_rvalid stores mem_rdata into refill beat[cnt] and advances cnt; beat BEATS-1 goes to FILL.
- FILL:
  - cache_en=cache_fill=1; cache_byte_en all ones.
  - cache_din = refill block with the latched store bytes overlaid at the latched woff (writes only).
  - cache_set_dirty = latched write & |byte_sel.
  - stall=1; next state is RESP.
- RESP:
  - stall=0 for exactly one cycle; no array access; ren/wen are ignored.
  - For a read, dout = merged block word at the latched woff.
  - Next state is IDLE.
- Latency
  - Clean miss: 1 (miss) + RD_REQ wait + BEATS rvalid beats + FILL + RESP.
  - stall is high from the miss cycle through FILL inclusive.
- Mandatory boundaries
  - BEATS=1 (single-beat bursts).
  - req_ready asserted in the same cycle as valid, giving zero wait.
  - Back-to-back misses: the next miss is detected in the IDLE cycle after RESP.
- Counters saturate at all ones and never wrap.
- mem_req_valid stays high until ready; its address and write flag are stable meanwhile.

Test Plan:
- Reset is asserted, then a read hit at addr 0x0000_0108 with cache_dout word2=0xDEADBEEF. Required: dout=0xDEADBEEF, stall=0, hit_count=1.
- Write hit at addr 0x0C, byte_sel=4'b0011, din=0x0000_1234. Required: cache_byte_en=16'h3000, cache_set_dirty=1, stall=0.
- Clean read miss at 0x200 with ready immediate and rdata beats 0x11,0x22,0x33,0x44. Required:
  - The fill block equals {0x44,0x33,0x22,0x11}.
  - RESP dout=0x11.
  - stall=1 for exactly 7 cycles.
  - miss_count=1, wb_count=0.
- Dirty write miss at 0x204, victim_ba=0x30 with block {A,B,C,D}, wready toggling every other cycle, byte_sel=4'b1000, din=0xFF00_0000. Required:
  - Write beats A,B,C,D are each held until accepted.
  - Read request follows at ba=0x20.
  - The filled word1 top byte is 0xFF; cache_set_dirty=1.
- Reset asserted during WB_DATA beat 2. Required: all outputs drop to 0 asynchronously, and state is IDLE after release.
- CNT_W=2 with five read hits. Required: hit_count saturates at 3.

Source files
------------

// File: rtl/dcache_burst_controller.sv
// L1 D-cache controller: zero-cycle hits; misses write back the dirty victim, then refill over valid/ready bursts.
// Misses stall from the miss cycle through FILL; memory backpressure (req_ready/wready) extends the stall, and rvalid is never backpressured.
module dcache_burst_controller #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int MEM_W       = 32,
    parameter int CNT_W       = 16,
    localparam int BLOCK_W    = BLOCK_WORDS * WORD_W,
    localparam int BEATS      = BLOCK_W / MEM_W,
    localparam int WBYTES     = WORD_W / 8,
    localparam int WOFF_W     = $clog2(WBYTES),
    localparam int BOFF_W     = WOFF_W + $clog2(BLOCK_WORDS),
    localparam int BA_W       = ADDR_W - BOFF_W,
    localparam int BBYTES     = BLOCK_W / 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ren,
    input  logic                wen,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [WBYTES-1:0]   byte_sel,
    input  logic [WORD_W-1:0]   din,
    output logic                stall,
    output logic [WORD_W-1:0]   dout,
    input  logic                cache_hit,
    input  logic                cache_dirty,
    input  logic [BA_W-1:0]     cache_victim_ba,
    input  logic [BLOCK_W-1:0]  cache_dout,
    output logic                cache_en,
    output logic                cache_wen,
    output logic                cache_fill,
    output logic [BBYTES-1:0]   cache_byte_en,
    output logic [BLOCK_W-1:0]  cache_din,
    output logic                cache_set_dirty,
    output logic                mem_req_valid,
    output logic                mem_req_write,
    input  logic                mem_req_ready,
    output logic [BA_W-1:0]     mem_block_addr,
    output logic [MEM_W-1:0]    mem_wdata,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    input  logic [MEM_W-1:0]    mem_rdata,
    input  logic                mem_rvalid,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count,
    output logic [CNT_W-1:0]    wb_count
);
    localparam int WIDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int CIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA, FILL, RESP} state_t;

    state_t               state, state_nxt;
    logic [CIDX_W-1:0]    cnt;
    logic [ADDR_W-1:0]    l_addr;
    logic [WORD_W-1:0]    l_din;
    logic [WBYTES-1:0]    l_bsel;
    logic                 l_wr;
    logic [BA_W-1:0]      l_vba;
    logic [BLOCK_W-1:0]   vbuf;
    logic [BLOCK_W-1:0]   rbuf;
    logic [BLOCK_W-1:0]   merged;
    logic [WIDX_W-1:0]    woff, l_woff;
    logic [BBYTES-1:0]    hit_be, fill_be;
    logic                 req, hit, miss, last_beat;

    // Gating req with reset keeps every output quiet while reset is held.
    assign req       = reset & (ren | wen);
    assign hit       = (state == IDLE) && req && cache_hit;
    assign miss      = (state == IDLE) && req && !cache_hit;
    assign woff      = WIDX_W'((addr >> WOFF_W) & ADDR_W'(BLOCK_WORDS - 1));
    assign l_woff    = WIDX_W'((l_addr >> WOFF_W) & ADDR_W'(BLOCK_WORDS - 1));
    assign hit_be    = BBYTES'(byte_sel) << (int'(woff) * WBYTES);
    assign fill_be   = l_wr ? (BBYTES'(l_bsel) << (int'(l_woff) * WBYTES)) : '0;
    assign last_beat = (cnt == CIDX_W'(BEATS - 1));

    // Pending store bytes overlaid on the refilled block.
    always_comb begin
        merged = rbuf;
        for (int b = 0; b < BBYTES; b++) begin
            if (fill_be[b]) merged[b*8 +: 8] = l_din[(b % WBYTES)*8 +: 8];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            l_addr <= '0;
            l_din  <= '0;
            l_bsel <= '0;
            l_wr   <= 1'b0;
            l_vba  <= '0;
            vbuf   <= '0;
            rbuf   <= '0;
        end else begin
            state <= state_nxt;
            if (miss) begin
                l_addr <= addr;
                l_din  <= din;
                l_bsel <= byte_sel;
                l_wr   <= wen;
                l_vba  <= cache_victim_ba;
                vbuf   <= cache_dout;
            end
            case (state)
                WB_REQ:  if (mem_req_ready) cnt <= '0;
                WB_DATA: if (mem_wready) cnt <= cnt + CIDX_W'(1);
                RD_REQ:  if (mem_req_ready) cnt <= '0;
                RD_DATA: if (mem_rvalid) begin
                    rbuf[int'(cnt)*MEM_W +: MEM_W] <= mem_rdata;
                    cnt <= cnt + CIDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            if (miss && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            if (miss && cache_dirty && wb_count != '1) wb_count <= wb_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt       = state;
        stall           = 1'b0;
        dout            = '0;
        cache_en        = 1'b0;
        cache_wen       = 1'b0;
        cache_fill      = 1'b0;
        cache_byte_en   = '0;
        cache_din       = '0;
        cache_set_dirty = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_write   = 1'b0;
        mem_block_addr  = '0;
        mem_wdata       = '0;
        mem_wvalid      = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (cache_hit) begin
                    if (wen) begin
                        cache_en        = 1'b1;
                        cache_wen       = 1'b1;
                        cache_byte_en   = hit_be;
                        cache_din       = {BLOCK_WORDS{din}};
                        cache_set_dirty = |byte_sel;
                    end else begin
                        dout = cache_dout[int'(woff)*WORD_W +: WORD_W];
                    end
                end else begin
                    stall     = 1'b1;
                    state_nxt = cache_dirty ? WB_REQ : RD_REQ;
                end
            end
            WB_REQ: begin
                stall          = 1'b1;
                mem_req_valid  = 1'b1;
                mem_req_write  = 1'b1;
                mem_block_addr = l_vba;
                if (mem_req_ready) state_nxt = WB_DATA;
            end
            WB_DATA: begin
                stall      = 1'b1;
                mem_wvalid = 1'b1;
                mem_wdata  = vbuf[int'(cnt)*MEM_W +: MEM_W];
                if (mem_wready && last_beat) state_nxt = RD_REQ;
            end
            RD_REQ: begin
                stall          = 1'b1;
                mem_req_valid  = 1'b1;
                mem_block_addr = BA_W'(l_addr >> BOFF_W);
                if (mem_req_ready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                stall = 1'b1;
                if (mem_rvalid && last_beat) state_nxt = FILL;
            end
            FILL: begin
                stall           = 1'b1;
                cache_en        = 1'b1;
                cache_fill      = 1'b1;
                cache_byte_en   = '1;
                cache_din       = merged;
                cache_set_dirty = l_wr & (|l_bsel);
                state_nxt       = RESP;
            end
            RESP: begin
                if (!l_wr) dout = merged[int'(l_woff)*WORD_W +: WORD_W];
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
